// File: rtl/one_unit_iter_ctrl.sv
// rtl/one_unit_iter_ctrl.sv - FastICA one-unit iteration sequencer (sample stream, normalise, converge check)
// Optional abort input enabled by defining ONE_UNIT_ABORT_EN.
module one_unit_iter_ctrl #(
  parameter int SAMPLES  = 256,
  parameter int ADDR_W   = 8,
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 7,
  parameter int MUL_LAT  = 1,
  parameter int CONV_TH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef ONE_UNIT_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              smp_rd,
  output logic [ADDR_W-1:0] smp_addr,
  output logic              en_mul,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              norm_start,
  input  logic              norm_done,
  input  logic [25:0]       delta
);

  localparam int DRN_W = $clog2(MUL_LAT + 2) + 1;

  typedef enum logic [2:0] {
    IDLE, CLR, RUN, DRAIN, NORM, NWAIT, CHECK, DONE
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  k;
  logic [DRN_W-1:0]   drn;
  logic [25:0]        delta_q;
  logic [25:0]        mag;
  logic [MUL_LAT-1:0] acc_pipe;
  logic               conv_hit;
  logic               abort_hit;

`ifdef ONE_UNIT_ABORT_EN
  assign abort_hit = abort && (state != IDLE) && (state != DONE);
`else
  assign abort_hit = 1'b0;
`endif

  // |delta| in 26 bits; the most negative code has no positive twin, so clamp it.
  always_comb begin
    mag = delta_q;
    if (delta_q[25]) begin
      if (delta_q == 26'h2000000) mag = 26'h1FFFFFF;
      else                        mag = 26'(-delta_q);
    end
  end
  assign conv_hit = (mag <= 26'(CONV_TH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CLR;
      CLR:     state_n = RUN;
      RUN:     if (k == ADDR_W'(SAMPLES - 1)) state_n = DRAIN;
      DRAIN:   if (drn == DRN_W'(MUL_LAT)) state_n = NORM;
      NORM:    state_n = NWAIT;
      NWAIT:   if (norm_done) state_n = CHECK;
      CHECK: begin
        if (conv_hit || iter_cnt == ITER_W'(MAX_ITER - 1)) state_n = DONE;
        else                                                 state_n = CLR;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_hit) state_n = DONE;
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    acc_clr    = (state == CLR);
    smp_rd     = (state == RUN);
    smp_addr   = (state == RUN) ? k : '0;
    norm_start = (state == NORM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= '0;
      drn       <= '0;
      iter_cnt  <= '0;
      converged <= 1'b0;
      delta_q   <= '0;
    end else begin
      if (state == RUN && k != ADDR_W'(SAMPLES - 1)) k <= k + 1'b1;
      else                                          k <= '0;

      if (state == DRAIN) drn <= drn + 1'b1;
      else                drn <= '0;

      if (state == IDLE && start)                 iter_cnt <= '0;
      else if (state == CHECK && state_n == CLR)  iter_cnt <= iter_cnt + 1'b1;

      if (abort_hit)                  converged <= 1'b0;
      else if (state == IDLE && start) converged <= 1'b0;
      else if (state == CHECK)         converged <= conv_hit;

      if (state == NWAIT && norm_done) delta_q <= delta;
    end
  end

  // en_mul follows the 1-cycle memory read; acc_en trails en_mul by the multiplier latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_mul   <= 1'b0;
      acc_pipe <= '0;
    end else if (abort_hit) begin
      en_mul   <= 1'b0;
      acc_pipe <= '0;
    end else begin
      en_mul      <= smp_rd;
      acc_pipe[0] <= en_mul;
      for (int i = 1; i < MUL_LAT; i++) acc_pipe[i] <= acc_pipe[i-1];
    end
  end
  assign acc_en = acc_pipe[MUL_LAT-1];

endmodule

// File: tb/tb_one_unit_iter_ctrl.sv
// tb/tb_one_unit_iter_ctrl.sv - scoreboard bench for one_unit_iter_ctrl (SAMPLES=4, MAX_ITER=3, MUL_LAT=1)
module tb_one_unit_iter_ctrl;

  localparam int SAMPLES  = 4;
  localparam int ADDR_W   = 2;
  localparam int MAX_ITER = 3;
  localparam int ITER_W   = 3;
  localparam int MUL_LAT  = 1;
  localparam int CONV_TH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              busy, done, converged, smp_rd, en_mul, acc_clr, acc_en, norm_start;
  logic [ITER_W-1:0] iter_cnt;
  logic [ADDR_W-1:0] smp_addr;
  logic              resp_done = 1'b0;
  logic              stray_done = 1'b0;
  logic              norm_done;
  logic [25:0]       delta = '0;

  assign norm_done = resp_done | stray_done;

  one_unit_iter_ctrl #(
    .SAMPLES(SAMPLES), .ADDR_W(ADDR_W), .MAX_ITER(MAX_ITER),
    .ITER_W(ITER_W), .MUL_LAT(MUL_LAT), .CONV_TH(CONV_TH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ONE_UNIT_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .converged(converged), .iter_cnt(iter_cnt),
    .smp_rd(smp_rd), .smp_addr(smp_addr), .en_mul(en_mul), .acc_clr(acc_clr),
    .acc_en(acc_en), .norm_start(norm_start), .norm_done(norm_done), .delta(delta)
  );

  always #5 clk = ~clk;

  typedef struct {
    int conv;
    int iter;
    int n_clr;
    int n_en;
    int n_acc;
  } done_t;

  int          exp_addr[$];
  done_t       exp_done[$];
  logic [25:0] delta_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int done_seen = 0;
  int n_clr = 0, n_en = 0, n_acc = 0;
  logic prev_rd = 1'b0, prev_en = 1'b0, prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read or a done.
  always @(negedge clk) begin
    if (rst) begin
      n_clr = 0; n_en = 0; n_acc = 0;
      prev_rd = 1'b0; prev_en = 1'b0; prev_done = 1'b0;
    end else begin
      if (smp_rd) begin
        if (exp_addr.size() == 0) chk("unexpected_smp_rd", 1, 0);
        else chk("smp_addr", int'(smp_addr), exp_addr.pop_front());
      end
      chk("en_mul_align", int'(en_mul), int'(prev_rd));
      chk("acc_en_align", int'(acc_en), int'(prev_en));
      if (prev_done) chk("busy_after_done", int'(busy), 0);
      n_clr += int'(acc_clr);
      n_en  += int'(en_mul);
      n_acc += int'(acc_en);
      if (done) begin
        chk("busy_in_done", int'(busy), 1);
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          done_t e;
          e = exp_done.pop_front();
          chk("converged", int'(converged), e.conv);
          chk("iter_cnt", int'(iter_cnt), e.iter);
          chk("acc_clr_count", n_clr, e.n_clr);
          chk("en_mul_count", n_en, e.n_en);
          chk("acc_en_count", n_acc, e.n_acc);
        end
        n_clr = 0; n_en = 0; n_acc = 0;
        done_seen++;
      end
      prev_rd = smp_rd; prev_en = en_mul; prev_done = done;
    end
  end

  // Normaliser model: answers each norm_start 3 cycles later with the next queued delta.
  initial begin
    forever begin
      @(negedge clk);
      if (norm_start && !rst) begin
        logic [25:0] d;
        if (delta_q.size() == 0) begin
          chk("delta_queue_empty", 1, 0);
          d = 26'd0;
        end else d = delta_q.pop_front();
        repeat (3) @(posedge clk);
        #1 resp_done = 1'b1; delta = d;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  task automatic expect_run(input int passes, input int conv, input int iter);
    done_t e;
    for (int p = 0; p < passes; p++)
      for (int a = 0; a < SAMPLES; a++) exp_addr.push_back(a);
    e.conv = conv; e.iter = iter; e.n_clr = passes;
    e.n_en = passes * SAMPLES; e.n_acc = passes * SAMPLES;
    exp_done.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int cyc = 0;
    while (done_seen < target && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (done_seen < target) chk("done_timeout", done_seen, target);
    @(posedge clk);
  endtask

  task automatic wait_done_sig();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 500);
    if (!done) chk("done_sig_timeout", 0, 1);
  endtask

  int total;

  initial begin
    total = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_smp_rd", int'(smp_rd), 0);
    chk("rst_en_mul", int'(en_mul), 0);
    chk("rst_acc_en", int'(acc_en), 0);
    chk("rst_iter_cnt", int'(iter_cnt), 0);
    chk("rst_converged", int'(converged), 0);
    rst = 1'b0;

    // T1: single pass converging, plus first-read latency
    delta_q.push_back(26'd5);
    expect_run(1, 1, 0); total++;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("t1_acc_clr_cycle1", int'(acc_clr), 1);
    chk("t1_no_rd_cycle1", int'(smp_rd), 0);
    @(posedge clk); #1;
    chk("t1_first_rd_cycle2", int'(smp_rd), 1);
    chk("t1_first_addr", int'(smp_addr), 0);
    wait_done(total);

    // T2: never converges, hits MAX_ITER
    for (int i = 0; i < 3; i++) delta_q.push_back(26'd100);
    expect_run(3, 0, 2); total++;
    pulse_start(); wait_done(total);

    // T3: negative delta converges by magnitude; most negative code never converges; threshold edge
    delta_q.push_back(26'd100); delta_q.push_back(26'd100); delta_q.push_back(26'h3FFFFF8);
    expect_run(3, 1, 2); total++;
    pulse_start(); wait_done(total);
    for (int i = 0; i < 3; i++) delta_q.push_back(26'h2000000);
    expect_run(3, 0, 2); total++;
    pulse_start(); wait_done(total);
    delta_q.push_back(26'd9); delta_q.push_back(26'd8);
    expect_run(2, 1, 1); total++;
    pulse_start(); wait_done(total);

    // T4: reset mid-RUN at k=2, then a clean restart
    exp_addr.push_back(0); exp_addr.push_back(1); exp_addr.push_back(2);
    pulse_start();
    begin
      int cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!(smp_rd && smp_addr == 2'd2) && cyc < 50);
      if (cyc >= 50) chk("t4_k2_timeout", 0, 1);
    end
    #1 rst = 1'b1;
    #1;
    chk("t4_busy", int'(busy), 0);
    chk("t4_smp_rd", int'(smp_rd), 0);
    chk("t4_smp_addr", int'(smp_addr), 0);
    chk("t4_acc_en", int'(acc_en), 0);
    chk("t4_en_mul", int'(en_mul), 0);
    chk("t4_converged", int'(converged), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t4_addr_queue_drained", exp_addr.size(), 0);
    delta_q.push_back(26'd5);
    expect_run(1, 1, 0); total++;
    pulse_start(); wait_done(total);

    // T5: start held high with stray norm_done in RUN
    delta_q.push_back(26'd5); delta_q.push_back(26'd5);
    expect_run(1, 1, 0); expect_run(1, 1, 0);
    @(posedge clk); #1 start = 1'b1;
    begin
      int cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!smp_rd && cyc < 50);
    end
    #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    wait_done_sig();
    @(posedge clk);
    @(negedge clk);
    chk("t5_idle_after_done", int'(busy), 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("t5_rerun_from_idle", int'(acc_clr), 1);
    total += 2;
    wait_done(total);

`ifdef ONE_UNIT_ABORT_EN
    // T6: abort coincident with norm_done in NWAIT
    delta_q.push_back(26'd5);
    expect_run(1, 0, 0); total++;
    pulse_start();
    begin
      int cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!norm_start && cyc < 50);
    end
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("t6_done_after_abort", int'(done), 1);
    wait_done(total);
`endif

    repeat (4) @(posedge clk);
    chk("final_done_count", done_seen, total);
    chk("final_addr_queue", exp_addr.size(), 0);
    chk("final_done_queue", exp_done.size(), 0);
    chk("final_delta_queue", delta_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
